// File: rtl/pwm_clock_divider_if.sv
// Write port of the PWM clock divider: one strobe loads one shadow register
// (period or high time) of one channel.
interface pwm_clock_divider_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 12
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             wr_en;
  logic [CW-1:0]    wr_chan;
  logic             wr_sel;
  logic [WIDTH-1:0] wr_data;

  modport master (output wr_en, output wr_chan, output wr_sel, output wr_data);
  modport slave  (input  wr_en, input  wr_chan, input  wr_sel, input  wr_data);
endinterface

// File: rtl/pwm_clock_divider.sv
// Multi-channel programmable clock divider / PWM generator. Settings are
// written into shadow registers and reach the active set only at a period boundary.
module pwm_clock_divider #(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 12,
  parameter int DEFAULT_PERIOD = 390,
  parameter int DEFAULT_HIGH   = 195
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [CHANNELS-1:0] enable,
  pwm_clock_divider_if.slave  wr,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [CHANNELS-1:0] period_tick,
  output logic [CHANNELS-1:0] update_pending
);

  localparam logic [WIDTH-1:0] DEF_PER = WIDTH'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0] DEF_HI  = WIDTH'(DEFAULT_HIGH);

  logic [WIDTH-1:0]    cnt_q    [CHANNELS];
  logic [WIDTH-1:0]    cnt_d    [CHANNELS];
  logic [WIDTH-1:0]    per_act_q[CHANNELS];
  logic [WIDTH-1:0]    per_act_d[CHANNELS];
  logic [WIDTH-1:0]    hi_act_q [CHANNELS];
  logic [WIDTH-1:0]    hi_act_d [CHANNELS];
  logic [WIDTH-1:0]    per_sh_q [CHANNELS];
  logic [WIDTH-1:0]    per_sh_d [CHANNELS];
  logic [WIDTH-1:0]    hi_sh_q  [CHANNELS];
  logic [WIDTH-1:0]    hi_sh_d  [CHANNELS];
  logic [CHANNELS-1:0] en_q;
  logic [CHANNELS-1:0] pend_q;
  logic [CHANNELS-1:0] pend_d;
  logic [CHANNELS-1:0] hit;

  always_comb begin
    cnt_d     = cnt_q;
    per_act_d = per_act_q;
    hi_act_d  = hi_act_q;
    per_sh_d  = per_sh_q;
    hi_sh_d   = hi_sh_q;
    pend_d    = pend_q;
    hit       = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      // Out-of-range wr_chan matches no loop index, so it is dropped here.
      hit[i] = wr.wr_en && (32'(wr.wr_chan) == i);
      if (hit[i] && !wr.wr_sel) per_sh_d[i] = wr.wr_data;
      if (hit[i] &&  wr.wr_sel) hi_sh_d[i]  = wr.wr_data;
      // Load from the post-write shadow so a write on a wrap/idle edge bypasses.
      if (!en_q[i] || (cnt_q[i] == per_act_q[i])) begin
        cnt_d[i]     = '0;
        per_act_d[i] = per_sh_d[i];
        hi_act_d[i]  = hi_sh_d[i];
        pend_d[i]    = 1'b0;
      end else begin
        cnt_d[i]  = cnt_q[i] + WIDTH'(1);
        pend_d[i] = pend_q[i] | hit[i];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i]     <= '0;
        per_act_q[i] <= DEF_PER;
        hi_act_q[i]  <= DEF_HI;
        per_sh_q[i]  <= DEF_PER;
        hi_sh_q[i]   <= DEF_HI;
      end
      en_q   <= '0;
      pend_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      per_act_q <= per_act_d;
      hi_act_q  <= hi_act_d;
      per_sh_q  <= per_sh_d;
      hi_sh_q   <= hi_sh_d;
      en_q      <= enable;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    pwm_out     = '0;
    period_tick = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      pwm_out[i]     = en_q[i] && (cnt_q[i] < hi_act_q[i]);
      period_tick[i] = en_q[i] && (cnt_q[i] == per_act_q[i]);
    end
    update_pending = pend_q;
  end

endmodule

// File: tb/tb_pwm_clock_divider.sv
// Directed bench for pwm_clock_divider: three channels so that wr_chan = CHANNELS
// is representable on the 2-bit write channel field.
module tb_pwm_clock_divider;
  localparam int CH = 3;
  localparam int W  = 12;

  logic          clock = 1'b0;
  logic          resetn;
  logic [CH-1:0] enable;
  logic [CH-1:0] pwm_out;
  logic [CH-1:0] period_tick;
  logic [CH-1:0] update_pending;

  int checks = 0;
  int passed = 0;

  pwm_clock_divider_if #(.CHANNELS(CH), .WIDTH(W)) wr_if ();

  pwm_clock_divider #(
    .CHANNELS(CH),
    .WIDTH(W),
    .DEFAULT_PERIOD(390),
    .DEFAULT_HIGH(195)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .enable(enable),
    .wr(wr_if),
    .pwm_out(pwm_out),
    .period_tick(period_tick),
    .update_pending(update_pending)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Advance to the next falling edge: outputs reflect the current cycle,
  // and inputs driven afterwards are sampled on the following rising edge.
  task automatic step();
    @(negedge clock);
    wr_if.wr_en = 1'b0;
  endtask

  task automatic drive_wr(input logic [1:0] ch, input logic sel, input logic [W-1:0] d);
    wr_if.wr_en   = 1'b1;
    wr_if.wr_chan = ch;
    wr_if.wr_sel  = sel;
    wr_if.wr_data = d;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    enable = '0;
    wr_if.wr_en = 1'b0; wr_if.wr_chan = '0; wr_if.wr_sel = 1'b0; wr_if.wr_data = '0;
    repeat (3) step();
    checks++; if (pwm_out !== 3'b000) $display("FAIL rst_pwm got %b exp 000", pwm_out); else passed++;
    checks++; if (period_tick !== 3'b000) $display("FAIL rst_tick got %b exp 000", period_tick); else passed++;
    checks++; if (update_pending !== 3'b000) $display("FAIL rst_pend got %b exp 000", update_pending); else passed++;
    resetn = 1'b1;
    step();
    checks++;
    if ({pwm_out, period_tick, update_pending} !== 9'b0)
      $display("FAIL post_rst_outs got %b exp 0", {pwm_out, period_tick, update_pending});
    else passed++;
  endtask

  task automatic test_defaults();
    int hi_cnt = 0;
    int first_low = -1;
    int tick_cnt = 0;
    int tick_a = -1;
    int tick_b = -1;
    enable[0] = 1'b1;
    for (int j = 0; j < 782; j++) begin
      step();
      if (j < 391 && pwm_out[0]) hi_cnt++;
      if (first_low < 0 && !pwm_out[0]) first_low = j;
      if (period_tick[0]) begin
        tick_cnt++;
        if (tick_a < 0) tick_a = j; else tick_b = j;
      end
      if (j == 391) begin
        checks++; if (pwm_out[0] !== 1'b1) $display("FAIL def_restart_pwm got %b exp 1", pwm_out[0]); else passed++;
      end
    end
    checks++; if (hi_cnt != 195) $display("FAIL def_high_cycles got %0d exp 195", hi_cnt); else passed++;
    checks++; if (first_low != 195) $display("FAIL def_first_low got %0d exp 195", first_low); else passed++;
    checks++; if (tick_cnt != 2) $display("FAIL def_tick_count got %0d exp 2", tick_cnt); else passed++;
    checks++; if (tick_a != 390) $display("FAIL def_tick1 got %0d exp 390", tick_a); else passed++;
    checks++; if (tick_b != 781) $display("FAIL def_tick2 got %0d exp 781", tick_b); else passed++;
    enable[0] = 1'b0;
    step();
    checks++; if (pwm_out[0] !== 1'b0 || period_tick[0] !== 1'b0)
      $display("FAIL def_disable got pwm=%b tick=%b exp 0 0", pwm_out[0], period_tick[0]); else passed++;
  endtask

  task automatic test_shadow_update();
    logic [24:0] exp_tick = 25'h1084200;
    logic [24:0] exp_pend = 25'h00003F8;
    logic [24:0] exp_pwm  = 25'h0739C07;
    step(); drive_wr(2'd1, 1'b0, 12'd9);
    step(); drive_wr(2'd1, 1'b1, 12'd3);
    step(); enable[1] = 1'b1;
    for (int j = 0; j < 25; j++) begin
      step();
      checks++; if (period_tick[1] !== exp_tick[j]) $display("FAIL shadow_tick j=%0d got %b exp %b", j, period_tick[1], exp_tick[j]); else passed++;
      checks++; if (update_pending[1] !== exp_pend[j]) $display("FAIL shadow_pend j=%0d got %b exp %b", j, update_pending[1], exp_pend[j]); else passed++;
      checks++; if (pwm_out[1] !== exp_pwm[j]) $display("FAIL shadow_pwm j=%0d got %b exp %b", j, pwm_out[1], exp_pwm[j]); else passed++;
      if (j == 2) drive_wr(2'd1, 1'b0, 12'd4);
    end
  endtask

  task automatic test_duty_extremes();
    step(); drive_wr(2'd2, 1'b0, 12'd9);
    step(); drive_wr(2'd2, 1'b1, 12'd0);
    step(); enable[2] = 1'b1;
    for (int j = 0; j < 20; j++) begin
      step();
      checks++; if (pwm_out[2] !== 1'b0) $display("FAIL duty0_pwm j=%0d got %b exp 0", j, pwm_out[2]); else passed++;
      checks++; if (period_tick[2] !== ((j == 9) || (j == 19)))
        $display("FAIL duty0_tick j=%0d got %b exp %b", j, period_tick[2], (j == 9) || (j == 19)); else passed++;
    end
    enable[2] = 1'b0;
    step(); drive_wr(2'd2, 1'b1, 12'd10);
    step(); enable[2] = 1'b1;
    for (int j = 0; j < 20; j++) begin
      step();
      checks++; if (pwm_out[2] !== 1'b1) $display("FAIL duty_full_pwm j=%0d got %b exp 1", j, pwm_out[2]); else passed++;
    end
    drive_wr(2'd2, 1'b0, 12'd0);
    for (int j = 0; j < 5; j++) begin
      step();
      checks++; if (period_tick[2] !== 1'b1) $display("FAIL per0_tick j=%0d got %b exp 1", j, period_tick[2]); else passed++;
      checks++; if (pwm_out[2] !== 1'b1) $display("FAIL per0_pwm j=%0d got %b exp 1", j, pwm_out[2]); else passed++;
    end
    checks++; if (update_pending[2] !== 1'b0) $display("FAIL per0_pend got %b exp 0", update_pending[2]); else passed++;
    enable[2] = 1'b0;
  endtask

  task automatic test_write_on_wrap();
    bit found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (period_tick[1]) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) $display("FAIL wrap_find_tick got none exp tick within 10 cycles"); else passed++;
    drive_wr(2'd1, 1'b1, 12'd7);
    for (int j = 0; j < 5; j++) begin
      step();
      checks++; if (update_pending[1] !== 1'b0) $display("FAIL wrap_pend j=%0d got %b exp 0", j, update_pending[1]); else passed++;
      checks++; if (pwm_out[1] !== 1'b1) $display("FAIL wrap_pwm j=%0d got %b exp 1", j, pwm_out[1]); else passed++;
      checks++; if (period_tick[1] !== (j == 4)) $display("FAIL wrap_tick j=%0d got %b exp %b", j, period_tick[1], j == 4); else passed++;
    end
  endtask

  task automatic test_invalid_chan();
    enable[0] = 1'b1;
    step();
    drive_wr(2'd3, 1'b0, 12'd1);
    step();
    checks++; if (update_pending !== 3'b000) $display("FAIL inval_pend got %b exp 000", update_pending); else passed++;
    for (int j = 2; j < 12; j++) begin
      step();
      checks++; if (pwm_out[0] !== 1'b1) $display("FAIL inval_pwm0 j=%0d got %b exp 1", j, pwm_out[0]); else passed++;
      checks++; if (period_tick[0] !== 1'b0) $display("FAIL inval_tick0 j=%0d got %b exp 0", j, period_tick[0]); else passed++;
    end
  endtask

  task automatic test_disable_reenable();
    enable[1] = 1'b0;
    step();
    checks++; if (pwm_out[1] !== 1'b0 || period_tick[1] !== 1'b0)
      $display("FAIL dis_outs got pwm=%b tick=%b exp 0 0", pwm_out[1], period_tick[1]); else passed++;
    drive_wr(2'd1, 1'b0, 12'd6);
    step();
    checks++; if (update_pending[1] !== 1'b0) $display("FAIL dis_pend got %b exp 0", update_pending[1]); else passed++;
    drive_wr(2'd1, 1'b1, 12'd2);
    step();
    enable[1] = 1'b1;
    for (int j = 0; j < 7; j++) begin
      step();
      checks++; if (period_tick[1] !== (j == 6)) $display("FAIL reen_tick j=%0d got %b exp %b", j, period_tick[1], j == 6); else passed++;
      checks++; if (pwm_out[1] !== (j < 2)) $display("FAIL reen_pwm j=%0d got %b exp %b", j, pwm_out[1], j < 2); else passed++;
    end
  endtask

  task automatic test_async_reset();
    int hi0 = 0;
    int hi1 = 0;
    int t0 = 0;
    int t1 = 0;
    int last0 = -1;
    int last1 = -1;
    checks++; if (pwm_out[0] !== 1'b1) $display("FAIL arst_pre_pwm got %b exp 1", pwm_out[0]); else passed++;
    #2 resetn = 1'b0;
    #1;
    checks++; if (pwm_out !== 3'b000) $display("FAIL arst_pwm got %b exp 000", pwm_out); else passed++;
    checks++; if (period_tick !== 3'b000 || update_pending !== 3'b000)
      $display("FAIL arst_other got tick=%b pend=%b exp 000 000", period_tick, update_pending); else passed++;
    step();
    step();
    enable = 3'b011;
    resetn = 1'b1;
    for (int j = 0; j < 391; j++) begin
      step();
      if (pwm_out[0]) hi0++;
      if (pwm_out[1]) hi1++;
      if (period_tick[0]) begin t0++; last0 = j; end
      if (period_tick[1]) begin t1++; last1 = j; end
    end
    checks++; if (hi0 != 195) $display("FAIL arst_hi0 got %0d exp 195", hi0); else passed++;
    checks++; if (hi1 != 195) $display("FAIL arst_hi1 got %0d exp 195", hi1); else passed++;
    checks++; if (t0 != 1 || last0 != 390) $display("FAIL arst_tick0 got n=%0d at %0d exp n=1 at 390", t0, last0); else passed++;
    checks++; if (t1 != 1 || last1 != 390) $display("FAIL arst_tick1 got n=%0d at %0d exp n=1 at 390", t1, last1); else passed++;
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_shadow_update();
    test_duty_extremes();
    test_write_on_wrap();
    test_invalid_chan();
    test_disable_reenable();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
